// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-length encodings, sizing helpers and GF(2^8) xtime
package aes_pkg;
    localparam logic [1:0] KL_128 = 2'd0;
    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;
    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DONE} state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        return 4'd4 + {1'b0, kl, 1'b0};
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return 4'd10 + {1'b0, kl, 1'b0};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign s_o = SBOX[a_i];
endmodule

// File: rtl/aes_sub_word.sv
// aes_sub_word: 32-bit SubWord as four parallel S-box lookups
module aes_sub_word (
    input  logic [31:0] w_i,
    output logic [31:0] w_o
);
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a_i(w_i[8*g +: 8]), .s_o(w_o[8*g +: 8]));
    end
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: expands an AES-128/192/256 key into the stored word array and serves round keys by index
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int WPC     = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [255:0] key_in_i,
    input  logic [1:0]   key_len_i,
    output logic         key_err_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [3:0]   nr_o,
    input  logic         rd_en_i,
    input  logic [3:0]   rd_idx_i,
    output logic         rd_valid_o,
    output logic [127:0] rd_data_o
);
    state_t        state_q;
    logic [31:0]   w_q [MAX_WORDS];
    logic [5:0]    i_q;
    logic [3:0]    j_q, nk_q, nr_q;
    logic [7:0]    rcon_q;
    logic          key_err_q, rd_valid_q;
    logic [127:0]  rd_data_q;
    logic [31:0]   prev, sw_in, sw_out, t0, n0, n1;
    logic [3:0]    nk_in, j_nx, j_d;
    logic [5:0]    total, base;
    logic [127:0]  row, sel;
    logic          accept, last, fire;

    assign nk_in  = nk_of(key_len_i);
    assign accept = key_valid_i && state_q != ST_GEN && key_len_i != 2'd3;
    assign total  = {nr_q + 4'd1, 2'b00};
    assign last   = (i_q + 6'(WPC)) == total;
    assign j_nx   = j_q + 4'(WPC);
    assign j_d    = j_nx >= nk_q ? j_nx - nk_q : j_nx;
    assign base   = {rd_idx_i, 2'b00};
    assign fire   = rd_en_i && state_q == ST_DONE;

    aes_sub_word u_sub_word (.w_i(sw_in), .w_o(sw_out));

    // next word(s): only word i can fall on an Nk boundary or the AES-256 mid-point, so one SubWord serves both
    always_comb begin
        prev  = w_q[i_q - 6'd1];
        sw_in = j_q == 4'd0 ? {prev[23:0], prev[31:24]} : prev;
        t0    = j_q == 4'd0 ? sw_out ^ {rcon_q, 24'h0} : (nk_q == 4'd8 && j_q == 4'd4) ? sw_out : prev;
        n0    = w_q[i_q - {2'b00, nk_q}] ^ t0;
        n1    = w_q[i_q + 6'd1 - {2'b00, nk_q}] ^ n0;
        row   = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
        sel   = rd_idx_i <= nr_q ? row : 128'h0;
    end

    // control FSM: accept key, step word counter and rcon through generation
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            i_q       <= 6'd0;
            j_q       <= 4'd0;
            nk_q      <= 4'd4;
            nr_q      <= 4'd0;
            rcon_q    <= 8'h01;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= key_valid_i && state_q != ST_GEN && key_len_i == 2'd3;
            if (state_q == ST_GEN) begin
                i_q <= i_q + 6'(WPC);
                j_q <= j_d;
                if (j_q == 4'd0) rcon_q <= xtime(rcon_q);
                if (last) state_q <= ST_DONE;
            end else if (accept) begin
                state_q <= ST_GEN;
                i_q     <= {2'b00, nk_in};
                j_q     <= 4'd0;
                nk_q    <= nk_in;
                nr_q    <= nr_of(key_len_i);
                rcon_q  <= 8'h01;
            end
        end
    end

    // word array: key words on accept, generated words during expansion; unreset since reads are gated by done
    always_ff @(posedge clk_i) begin
        if (state_q == ST_GEN) begin
            w_q[i_q] <= n0;
            if (WPC == 2) w_q[i_q + 6'd1] <= n1;
        end else if (accept) begin
            for (int k = 0; k < 8; k++)
                if (4'(k) < nk_in) w_q[k] <= key_in_i[255 - 32*k -: 32];
        end
    end

    // read port register; also holds the last served key for the combinational variant
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 128'h0;
        end else begin
            rd_valid_q <= fire;
            if (fire) rd_data_q <= sel;
        end
    end

    assign key_ready_o = state_q != ST_GEN;
    assign busy_o      = state_q == ST_GEN;
    assign done_o      = state_q == ST_DONE;
    assign nr_o        = done_o ? nr_q : 4'd0;
    assign key_err_o   = key_err_q;
    assign rd_valid_o  = OUT_REG ? rd_valid_q : fire;
    assign rd_data_o   = OUT_REG ? rd_data_q : (fire ? sel : rd_data_q);
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

- Parametrised, multi-mode successor to the AES-256 on-the-fly key expander.
- Accepts a 128-, 192- or 256-bit cipher key through a valid/ready handshake and expands it into the full FIPS-197 word array (44/52/60 words).
- Stores the array internally and serves any round key by index, so the cipher core can walk forward (encrypt) or backward (decrypt) without re-expanding.
- Sits between the key-load interface and the AES round datapath.

## Interface
Parameters:
- WPC, default 1: words generated per cycle; legal values 1 or 2.
- OUT_REG, default 1: 1 = read data registered (1-cycle latency); 0 = combinational read (0 latency).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_valid  input  1  key_in/key_len valid.
- key_ready  output  1  block can accept a key.
- key_in  input  256  cipher key; w0 = key_in[255:224]; 128-bit keys use [255:128], 192-bit keys use [255:64].
- key_len  input  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal.
- key_err  output  1  one-cycle pulse: illegal key_len presented with key_valid.
- busy  output  1  expansion in progress.
- done  output  1  level: full schedule for the last accepted key is valid.
- nr  output  4  Nr of the stored key (10/12/14); 0 when not done.
- rd_en  input  1  round-key read request.
- rd_idx  input  4  round index 0..Nr.
- rd_valid  output  1  rd_data valid.
- rd_data  output  128  round key; word 4j in [127:96] through word 4j+3 in [31:0].

## Operation
- States:
  - IDLE: key_ready=1, done=0.
  - GEN: key_ready=0, busy=1.
  - DONE: key_ready=1, done=1.
- Accept = key_valid && key_ready && key_len!=3. On accept:
  - Words 0..Nk-1 are written from key_in (Nk = 4/6/8).
  - rcon is set to 0x01, the word counter i is set to Nk, and the FSM goes to GEN.
  - done drops in the same edge.
- key_valid && key_ready && key_len==3: no state change; key_err pulses the next cycle.
- Word generation (GEN), one word per cycle (WPC=1):
  - w[i] = w[i-Nk] ^ t.
  - If i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon <= xtime(rcon).
  - Else if Nk==8 and i mod 8 == 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
- WPC=2: words i and i+1 are produced in the same cycle. i is always even, and only word i ever needs SubWord, so one SubWord path suffices.
- GEN → DONE when the last word (index 4·(Nr+1)−1) is written. nr is latched at accept and is reported while done=1.
- Reads are honoured only in DONE:
  - rd_en && done && rd_idx<=nr: rd_valid=1 and rd_data = words 4·rd_idx..4·rd_idx+3.
  - rd_idx>nr: rd_valid=1, rd_data=0.
  - rd_en while not done: rd_valid=0, rd_data holds its previous value.
- A key may be accepted in DONE. Because reads are gated by done, a read issued in the same cycle as the accept is still served from the old schedule.
- Storage is 60×32 flops and is not reset. Stale contents are unobservable because reads are gated.

## Timing
- Reset values: key_ready=1, key_err=0, busy=0, done=0, nr=0, rd_valid=0, rd_data=0; FSM=IDLE; rcon=0x01.
- Key accepted at edge T: busy=1 from T.
- Generation cycles: 40/46/52 (WPC=1) or 20/23/26 (WPC=2) for AES-128/192/256.
  - done=1 and key_ready=1 from edge T+cycles.
  - busy=0 in the same cycle.
- Read latency:
  - OUT_REG=1: rd_valid/rd_data appear one cycle after rd_en; back-to-back reads give one result per cycle.
  - OUT_REG=0: same-cycle; rd_valid = rd_en && done.
- Reset asserted mid-GEN: the FSM goes to IDLE and all outputs take their reset values immediately (asynchronous). The partial schedule is discarded.
- key_valid held high during GEN is ignored; it is accepted once key_ready rises.

## Structure
- Shared package aes_pkg holds:
  - key_len encoding constants (KL_128, KL_192, KL_256).
  - functions nk_of(key_len) and nr_of(key_len).
  - function xtime(byte).
  - MAX_WORDS=60.
- Sub-module aes_sub_word: 32-bit SubWord built from four existing sbox instances; instantiated once.
- The FSM, word counter, rcon register, word array and read mux all live in aes_key_schedule.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c → done after 40 cycles (WPC=1); rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=0 returns the key.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 cycles, nr=12; rd_idx=12 → e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb10…0914dff4 (FIPS-197 A.3) → done after 52 cycles (26 with WPC=2); rd_idx=14 → fe4890d1e6188d0b046df344706c631e.
- Read rd_idx 14 down to 0 back-to-back → 15 consecutive rd_valid cycles in reverse order; rd_idx=13 after an AES-128 key → rd_valid=1, rd_data=0.
- key_len=3 with key_valid → key_err pulses one cycle; state unchanged; done keeps its prior value.
- Reset asserted at GEN cycle 20 → outputs at reset values immediately; a following AES-128 key still produces the correct round 10.
